pipelined_barrel_shifter: RTL and testbench

//  Parametrised, multi-mode barrel shifter for the EX stage: SLL/SRL/SRA/ROR on WIDTH-bit data.
//  Log2 mux stages (16/8/4/2/1 for WIDTH=32) with optional pipeline registers between stages.

---
 rtl/shifter_pkg.sv | 20 ++
 rtl/shift_stage.sv | 114 +++++++++++
 rtl/pipelined_barrel_shifter.sv | 111 +++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shift mode encodings and bit-reverse helper shared by the shifter and ALU decoder
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // Widest datapath the reverse helper covers; narrower callers align into the top bits first.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] d);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = d[MAX_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one log2 right-shift step with optional pipeline register
module shift_stage #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1,
  parameter int REG   = 1,
  parameter int SHW   = 5,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_fill,
  input  logic             in_rot,
  input  logic             in_rev,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_fill,
  output logic             out_rot,
  output logic             out_rev,
  output logic [TAG_W-1:0] out_tag
);

  localparam int BIT = $clog2(DIST);

  logic [WIDTH-1:0] shifted;

  // Shift right by DIST when this stage's amount bit is set, rotating or filling at the MSB end
  always_comb begin
    shifted = in_data;
    if (in_shamt[BIT]) begin
      if (in_rot) begin
        shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
      end else begin
        shifted = {{DIST{in_fill}}, in_data[WIDTH-1:DIST]};
      end
    end
  end

  if (REG != 0) begin : g_reg
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic             fill_q, fill_d;
    logic             rot_q, rot_d;
    logic             rev_q, rev_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // Load from the predecessor on advance (bubbles included), otherwise hold everything
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      shamt_d = shamt_q;
      fill_d  = fill_q;
      rot_d   = rot_q;
      rev_d   = rev_q;
      tag_d   = tag_q;
      if (advance) begin
        valid_d = in_valid;
        data_d  = shifted;
        shamt_d = in_shamt;
        fill_d  = in_fill;
        rot_d   = in_rot;
        rev_d   = in_rev;
        tag_d   = in_tag;
      end
    end

    // Stage register; reset drops whatever is in flight
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        shamt_q <= '0;
        fill_q  <= 1'b0;
        rot_q   <= 1'b0;
        rev_q   <= 1'b0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        shamt_q <= shamt_d;
        fill_q  <= fill_d;
        rot_q   <= rot_d;
        rev_q   <= rev_d;
        tag_q   <= tag_d;
      end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_shamt = shamt_q;
    assign out_fill  = fill_q;
    assign out_rot   = rot_q;
    assign out_rev   = rev_q;
    assign out_tag   = tag_q;
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, advance};

    assign out_valid = in_valid;
    assign out_data  = shifted;
    assign out_shamt = in_shamt;
    assign out_fill  = in_fill;
    assign out_rot   = in_rot;
    assign out_rev   = in_rev;
    assign out_tag   = in_tag;
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - SLL/SRL/SRA/ROR barrel shifter with valid/ready and tag sideband
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PIPELINED = 1,
  parameter int TAG_W     = 5,
  localparam int SHW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  function automatic logic [WIDTH-1:0] rev_w(input logic [WIDTH-1:0] d);
    logic [MAX_W-1:0] wide;
    wide = bit_reverse(MAX_W'(d) << (MAX_W - WIDTH));
    return wide[WIDTH-1:0];
  endfunction

  logic advance;

  // One global stall: everything moves only when the output slot is free or being drained
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // SLL runs through the right-shift core on reversed data; SRA fill is the operand MSB at accept
  logic [WIDTH-1:0] entry_data;
  logic             entry_fill;
  logic             entry_rot;
  logic             entry_rev;
  assign entry_rev  = (in_mode == MODE_SLL);
  assign entry_rot  = (in_mode == MODE_ROR);
  assign entry_fill = (in_mode == MODE_SRA) && in_data[WIDTH-1];
  assign entry_data = entry_rev ? rev_w(in_data) : in_data;

  // Stage SHW-1 (largest step) is fed from the input; stage 0 holds the output register
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic             i_v, o_v;
    logic [WIDTH-1:0] i_d, o_d;
    logic [SHW-1:0]   i_s, o_s;
    logic             i_f, o_f;
    logic             i_r, o_r;
    logic             i_rv, o_rv;
    logic [TAG_W-1:0] i_t, o_t;

    if (k == SHW-1) begin : g_head
      assign i_v  = in_valid;
      assign i_d  = entry_data;
      assign i_s  = in_shamt;
      assign i_f  = entry_fill;
      assign i_r  = entry_rot;
      assign i_rv = entry_rev;
      assign i_t  = in_tag;
    end else begin : g_link
      assign i_v  = g_stage[k+1].o_v;
      assign i_d  = g_stage[k+1].o_d;
      assign i_s  = g_stage[k+1].o_s;
      assign i_f  = g_stage[k+1].o_f;
      assign i_r  = g_stage[k+1].o_r;
      assign i_rv = g_stage[k+1].o_rv;
      assign i_t  = g_stage[k+1].o_t;
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .REG   (((PIPELINED != 0) || (k == 0)) ? 1 : 0),
      .SHW   (SHW),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .in_valid  (i_v),
      .in_data   (i_d),
      .in_shamt  (i_s),
      .in_fill   (i_f),
      .in_rot    (i_r),
      .in_rev    (i_rv),
      .in_tag    (i_t),
      .out_valid (o_v),
      .out_data  (o_d),
      .out_shamt (o_s),
      .out_fill  (o_f),
      .out_rot   (o_r),
      .out_rev   (o_rv),
      .out_tag   (o_t)
    );
  end

  logic unused_tail;
  assign unused_tail = ^{g_stage[0].o_s, g_stage[0].o_f, g_stage[0].o_r};

  // Undo the SLL reversal on exit; zero flag follows the registered result
  assign out_valid = g_stage[0].o_v;
  assign out_data  = g_stage[0].o_rv ? rev_w(g_stage[0].o_d) : g_stage[0].o_d;
  assign out_tag   = g_stage[0].o_t;
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - directed and randomized bench for both pipelined and single-register builds
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        sel;

  logic        p_in_ready, p_out_valid, p_out_zero;
  logic [31:0] p_out_data;
  logic [4:0]  p_out_tag;
  logic        c_in_ready, c_out_valid, c_out_zero;
  logic [31:0] c_out_data;
  logic [4:0]  c_out_tag;

  logic        o_in_ready, o_valid, o_zero;
  logic [31:0] o_data;
  logic [4:0]  o_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(32), .PIPELINED(1), .TAG_W(5)) dut_p (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p_in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
    .out_tag(p_out_tag), .out_zero(p_out_zero)
  );

  pipelined_barrel_shifter #(.WIDTH(32), .PIPELINED(0), .TAG_W(5)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .out_tag(c_out_tag), .out_zero(c_out_zero)
  );

  assign o_in_ready = sel ? p_in_ready  : c_in_ready;
  assign o_valid    = sel ? p_out_valid : c_out_valid;
  assign o_data     = sel ? p_out_data  : c_out_data;
  assign o_tag      = sel ? p_out_tag   : c_out_tag;
  assign o_zero     = sel ? p_out_zero  : c_out_zero;

  function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s);
    logic [63:0]        dd;
    logic signed [31:0] sd;
    case (m)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   begin sd = d; return sd >>> s; end
      default: begin dd = {d, d} >> s; return dd[31:0]; end
    endcase
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", o_valid); end
    checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h expected 00000000", o_data); end
    checks++; if (o_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag got %h expected 00", o_tag); end
    checks++; if (o_zero !== 1'b1) begin errors++; $display("FAIL reset_out_zero got %b expected 1", o_zero); end
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", o_in_ready); end
  endtask

  task automatic run_single(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s,
                            input logic [4:0] t, input logic [31:0] exp, input string name);
    int cyc;
    int lat;
    lat = sel ? 5 : 1;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    in_mode = m; in_data = d; in_shamt = s; in_tag = t;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!o_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (o_valid !== 1'b1 || cyc != lat) begin errors++; $display("FAIL %s latency got %0d expected %0d (pipelined=%b)", name, cyc, lat, sel); end
    checks++; if (o_data !== exp) begin errors++; $display("FAIL %s data got %h expected %h (pipelined=%b)", name, o_data, exp, sel); end
    checks++; if (o_tag !== t) begin errors++; $display("FAIL %s tag got %h expected %h", name, o_tag, t); end
    checks++; if (o_zero !== (exp == 32'h0)) begin errors++; $display("FAIL %s zero got %b expected %b", name, o_zero, (exp == 32'h0)); end
  endtask

  task automatic test_modes();
    reset_dut();
    run_single(2'b00, 32'h0000_0001, 5'd31, 5'd1, 32'h8000_0000, "sll_31");
    run_single(2'b01, 32'h8000_0000, 5'd31, 5'd2, 32'h0000_0001, "srl_31");
    run_single(2'b10, 32'h8000_0000, 5'd4,  5'd3, 32'hF800_0000, "sra_neg");
    run_single(2'b10, 32'h7000_0000, 5'd4,  5'd4, 32'h0700_0000, "sra_pos");
    run_single(2'b11, 32'h1234_5678, 5'd8,  5'd5, 32'h7812_3456, "ror_8");
    run_single(2'b00, 32'hDEAD_BEEF, 5'd0,  5'd6, 32'hDEAD_BEEF, "sll_0");
    run_single(2'b01, 32'hDEAD_BEEF, 5'd0,  5'd7, 32'hDEAD_BEEF, "srl_0");
    run_single(2'b10, 32'hDEAD_BEEF, 5'd0,  5'd8, 32'hDEAD_BEEF, "sra_0");
    run_single(2'b11, 32'hDEAD_BEEF, 5'd0,  5'd9, 32'hDEAD_BEEF, "ror_0");
    run_single(2'b01, 32'h0000_000F, 5'd4,  5'd10, 32'h0000_0000, "srl_zero");
    run_single(2'b00, 32'h0000_00F1, 5'd4,  5'd11, 32'h0000_0F10, "sll_4");
    run_single(2'b11, 32'h0000_0001, 5'd1,  5'd12, 32'h8000_0000, "ror_wrap");
  endtask

  task automatic test_back_to_back();
    int  sent, recv, inflight, cap, extra;
    bit  dropped, stalled;
    logic [31:0] hd;
    logic [4:0]  ht;
    cap = sel ? 5 : 1;
    reset_dut();
    sent = 0; recv = 0; dropped = 1'b0; stalled = 1'b0; hd = '0; ht = '0;
    for (int c = 0; c < 80 && recv < 8; c++) begin
      @(negedge clk);
      out_ready = (c < 3) || (c >= 12);
      in_valid  = (sent < 8);
      in_mode   = 2'b01;
      in_data   = 32'h8000_0000;
      in_shamt  = sent[4:0];
      in_tag    = sent[4:0];
      #1;
      if (stalled) begin
        checks++;
        if (o_data !== hd || o_tag !== ht) begin errors++; $display("FAIL b2b_hold data %h tag %h expected data %h tag %h", o_data, o_tag, hd, ht); end
      end
      inflight = sent - recv;
      if (!o_in_ready && !dropped) begin
        dropped = 1'b1;
        checks++;
        if (inflight != cap) begin errors++; $display("FAIL b2b_capacity got %0d in flight expected %0d", inflight, cap); end
      end
      if (o_valid && out_ready) begin
        checks++;
        if (o_tag !== recv[4:0] || o_data !== (32'h8000_0000 >> recv)) begin
          errors++; $display("FAIL b2b_order tag %h data %h expected tag %h data %h", o_tag, o_data, recv[4:0], 32'h8000_0000 >> recv);
        end
        recv++;
      end
      if (in_valid && o_in_ready) sent++;
      stalled = o_valid && !out_ready;
      hd = o_data; ht = o_tag;
    end
    checks++; if (recv != 8 || sent != 8 || !dropped) begin errors++; $display("FAIL b2b_count got sent %0d recv %0d dropped %b expected 8 8 1", sent, recv, dropped); end
    extra = 0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_valid) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_duplicate got %0d extra results expected 0", extra); end
  endtask

  task automatic test_reset_flush();
    int stale;
    reset_dut();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = 2'b11; in_data = 32'hFFFF_FFFF; in_shamt = 5'd0; in_tag = 5'(9 + i);
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b expected 0", o_valid); end
    checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL flush_out_data got %h expected 00000000", o_data); end
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b expected 1", o_in_ready); end
    rst = 1'b0; out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL flush_stale got %0d results expected 0", stale); end
  endtask

  task automatic test_random(input int n);
    logic [31:0] exp_q[$];
    logic [4:0]  tag_q[$];
    logic [31:0] ed;
    logic [4:0]  et;
    int sent, recv;
    reset_dut();
    sent = 0; recv = 0;
    for (int c = 0; c < n * 8 + 200 && recv < n; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < n) && ($urandom_range(0, 4) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      in_shamt  = 5'($urandom_range(0, 31));
      in_tag    = 5'($urandom_range(0, 31));
      #1;
      if (o_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious result data %h tag %h with nothing outstanding", o_data, o_tag);
        end else begin
          ed = exp_q.pop_front();
          et = tag_q.pop_front();
          if (o_data !== ed || o_tag !== et) begin
            errors++; $display("FAIL rand_result got data %h tag %h expected data %h tag %h", o_data, o_tag, ed, et);
          end
        end
        recv++;
      end
      if (in_valid && o_in_ready) begin
        exp_q.push_back(ref_shift(in_mode, in_data, in_shamt));
        tag_q.push_back(in_tag);
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++; if (recv != n) begin errors++; $display("FAIL rand_count got %0d results expected %0d", recv, n); end
  endtask

  initial begin
    sel = 1'b1;
    for (int b = 0; b < 2; b++) begin
      sel = (b == 0);
      test_reset();
      test_modes();
      test_back_to_back();
      test_reset_flush();
      test_random(sel ? 2000 : 10000);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
